// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider for the calculator's divide path: 7-bit unsigned
// operands, one quotient bit per clock, round-to-nearest with ties rounding down.
module div_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] A,
  input  logic [6:0] B,
  output logic       busy,
  output logic       done,
  output logic [7:0] S,
  output logic [6:0] R,
  output logic       flag
);

  localparam int DATA_W = 7;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic [2:0]        cnt;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic              ge;

  // The remainder stays below the divisor, so an 8-bit result cannot overflow.
  function automatic logic [DATA_W:0] round_q(input logic [DATA_W-1:0] q,
                                               input logic [DATA_W-1:0] r,
                                               input logic [DATA_W-1:0] d);
    logic [DATA_W:0] qe;
    qe = {1'b0, q};
    if (r > (d >> 1))
      round_q = qe + (DATA_W+1)'(1);
    else
      round_q = qe;
  endfunction

  always_comb begin
    trial = {rem, dvd[DATA_W-1]};
    diff  = trial - {1'b0, dvs};
    ge    = (trial >= {1'b0, dvs});
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      S     <= '0;
      R     <= '0;
      flag  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (B == '0) begin
              S     <= '0;
              R     <= '0;
              flag  <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              dvd   <= A;
              dvs   <= B;
              rem   <= '0;
              cnt   <= 3'd6;
              state <= DIV;
            end
          end
        end
        DIV: begin
          // Quotient bits shift in behind the dividend bits as they are consumed.
          rem <= ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
          dvd <= {dvd[DATA_W-2:0], ge};
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0)
            state <= ROUND;
        end
        ROUND: begin
          S     <= round_q(dvd, rem, dvs);
          R     <= rem;
          flag  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
